// File: rtl/intt_4_seq.sv
// Sequential 4-point inverse NTT over Z_q. One shared Gentleman-Sande butterfly
// and one modular multiplier, stepped by an FSM with valid/ready on both sides.
module intt_4_seq #(
    parameter int W     = 9,
    parameter int Q     = 257,
    parameter int W_INV = 241,
    parameter int N_INV = 193
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*W-1:0] A,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*W-1:0] an,
    output logic           busy
);

    typedef enum logic [3:0] {
        IDLE, B0, B1, B2, B3, S0, S1, S2, S3, OUT
    } state_t;

    localparam logic [W-1:0]   QW    = W'(Q);
    localparam logic [2*W-1:0] Q2    = (2*W)'(Q);
    localparam logic [W-1:0]   ONE   = W'(1);
    localparam logic [W-1:0]   WINVW = W'(W_INV);
    localparam logic [W-1:0]   NINVW = W'(N_INV);

    state_t         state, state_nxt;
    logic [W-1:0]   r [4];
    logic [W-1:0]   bf_x, bf_y, mul_a, mul_b;
    logic [W-1:0]   sum_q, diff_q, mul_q;
    logic [W:0]     sum_w;
    logic [2*W-1:0] prod;

    function automatic logic [W-1:0] reduce_once(input logic [W-1:0] c);
        return (c >= QW) ? c - QW : c;
    endfunction

    // Shared datapath: the multiplier takes the butterfly difference during
    // B0..B3 and a finished coefficient during the N_INV scaling states.
    always_comb begin
        bf_x  = r[0];
        bf_y  = r[2];
        mul_b = ONE;
        case (state)
            B1:             begin bf_x = r[1]; bf_y = r[3]; mul_b = WINVW; end
            B2:             begin bf_x = r[0]; bf_y = r[1]; end
            B3:             begin bf_x = r[2]; bf_y = r[3]; end
            S0, S1, S2, S3: mul_b = NINVW;
            default:        ;
        endcase

        sum_w  = {1'b0, bf_x} + {1'b0, bf_y};
        sum_q  = (sum_w >= {1'b0, QW}) ? W'(sum_w - {1'b0, QW}) : sum_w[W-1:0];
        diff_q = (bf_x >= bf_y) ? bf_x - bf_y
                                : W'({1'b0, bf_x} + {1'b0, QW} - {1'b0, bf_y});

        mul_a = diff_q;
        case (state)
            S0:      mul_a = r[0];
            S1:      mul_a = r[2];
            S2:      mul_a = r[1];
            S3:      mul_a = r[3];
            default: ;
        endcase

        prod  = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        mul_q = W'(prod % Q2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = B0;
            end
            B0:  state_nxt = B1;
            B1:  state_nxt = B2;
            B2:  state_nxt = B3;
            B3:  state_nxt = S0;
            S0:  state_nxt = S1;
            S1:  state_nxt = S2;
            S2:  state_nxt = S3;
            S3:  state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // After B2/B3 the registers hold {r0,r1,r2,r3} = {a0,a2,a1,a3}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < 4; k++) r[k] <= '0;
            an <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid)
                    for (int unsigned k = 0; k < 4; k++) r[k] <= reduce_once(A[W*k +: W]);
                B0: begin r[0] <= sum_q; r[2] <= mul_q; end
                B1: begin r[1] <= sum_q; r[3] <= mul_q; end
                B2: begin r[0] <= sum_q; r[1] <= mul_q; end
                B3: begin r[2] <= sum_q; r[3] <= mul_q; end
                S0: r[0] <= mul_q;
                S1: r[2] <= mul_q;
                S2: r[1] <= mul_q;
                S3: begin
                    r[3] <= mul_q;
                    an   <= {mul_q, r[1], r[2], r[0]};
                end
                default: ;
            endcase
        end
    end

endmodule
